// File: rtl/attack_pkg.sv
// Shared definitions for the attack arbiter: attack-word layout, hit tiers,
// hit damage, the arbiter FSM states and the attack-type decoder.
package attack_pkg;

  // Attack-word bit positions
  localparam int unsigned HIT     = 0;
  localparam int unsigned SMASH_U = 1;
  localparam int unsigned SMASH_D = 2;
  localparam int unsigned SMASH_L = 3;
  localparam int unsigned SMASH_R = 4;
  localparam int unsigned JAB     = 5;
  localparam int unsigned SPEC_U  = 6;
  localparam int unsigned SPEC_D  = 7;
  localparam int unsigned SPEC_L  = 8;
  localparam int unsigned SPEC_R  = 9;
  localparam int unsigned SPEC_N  = 10;
  localparam int unsigned ACTIVE  = 11;

  // Clash priority tiers (higher wins)
  localparam logic [1:0] TIER_SMASH   = 2'd3;
  localparam logic [1:0] TIER_SPECIAL = 2'd2;
  localparam logic [1:0] TIER_JAB     = 2'd1;

  // Damage dealt per hit type
  localparam logic [3:0] DMG_SMASH   = 4'd15;
  localparam logic [3:0] DMG_SPECIAL = 4'd10;
  localparam logic [3:0] DMG_NEUTRAL = 4'd8;
  localparam logic [3:0] DMG_JAB     = 4'd3;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    APPLY
  } arbState_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] tier;
    logic [3:0] dmg;
  } hitInfo_t;

  // The lowest set type bit decides the hit; the type groups are laid out in
  // ascending bit order, so a group-wise priority chain picks the lowest bit.
  function automatic hitInfo_t decodeType(input logic [SPEC_N:SMASH_U] typeBits);
    hitInfo_t info;
    info = '0;
    if (typeBits[SMASH_R:SMASH_U] != '0) begin
      info = '{valid: 1'b1, tier: TIER_SMASH, dmg: DMG_SMASH};
    end else if (typeBits[JAB]) begin
      info = '{valid: 1'b1, tier: TIER_JAB, dmg: DMG_JAB};
    end else if (typeBits[SPEC_R:SPEC_U] != '0) begin
      info = '{valid: 1'b1, tier: TIER_SPECIAL, dmg: DMG_SPECIAL};
    end else if (typeBits[SPEC_N]) begin
      info = '{valid: 1'b1, tier: TIER_SPECIAL, dmg: DMG_NEUTRAL};
    end
    return info;
  endfunction

endpackage

// File: rtl/attack_arbiter_kb_scaler.sv
// Scales one signed 16-bit knockback half by the victim's damage percent:
// k + (k*d)>>>7, clamped to the symmetric range [-32767, 32767].
module kb_scaler #(
  parameter int unsigned DMG_W = 10
) (
  input  logic signed [15:0]      base,
  input  logic        [DMG_W-1:0] damage,
  output logic signed [15:0]      scaled
);

  logic signed [31:0] base32;
  logic signed [31:0] damage32;
  logic signed [31:0] product;
  logic signed [31:0] sum;

  // Widen, scale, add back the base and saturate
  always_comb begin
    base32   = 32'(base);
    damage32 = $signed(32'(damage));
    product  = base32 * damage32;
    sum      = base32 + (product >>> 7);
    if (sum > 32'sd32767) begin
      scaled = 16'sh7FFF;
    end else if (sum < -32'sd32767) begin
      scaled = 16'sh8001;
    end else begin
      scaled = sum[15:0];
    end
  end

endmodule

// File: rtl/attack_arbiter.sv
// Attack arbiter: turns each player's attack word into at most one hit per
// attack instance, resolves simultaneous hits, accumulates damage, issues the
// victim's scaled knockback strobe and runs per-player hitstun.
module attack_arbiter #(
  parameter int unsigned        STUN_W      = 24,
  parameter logic [STUN_W-1:0]  STUN_CYCLES = 24'h400000,
  parameter int unsigned        DMG_W       = 10,
  parameter int unsigned        DMG_MAX     = 999
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      p1_attack,
  input  logic [31:0]      p1_knockback,
  input  logic [31:0]      p2_attack,
  input  logic [31:0]      p2_knockback,
  output logic [DMG_W-1:0] p1_damage,
  output logic [DMG_W-1:0] p2_damage,
  output logic [31:0]      p1_kb_out,
  output logic             p1_kb_valid,
  output logic [31:0]      p2_kb_out,
  output logic             p2_kb_valid,
  output logic             p1_stunned,
  output logic             p2_stunned,
  output logic             clash
);
  import attack_pkg::*;

  localparam logic [DMG_W:0]   DMG_LIMIT = (DMG_W+1)'(DMG_MAX);
  localparam logic [DMG_W-1:0] DMG_CAP   = DMG_W'(DMG_MAX);

  arbState_t         state, stateNext;
  hitInfo_t          p1Type, p2Type, p1Hit, p2Hit;
  logic              p1HitEv, p2HitEv;
  logic              p1Consumed, p2Consumed, p1Lockout, p2Lockout;
  logic              p1Pending, p2Pending;
  logic [31:0]       p1KbBase, p2KbBase;
  logic [STUN_W-1:0] p1StunCount, p2StunCount;
  logic              p1Stun, p2Stun;
  logic [DMG_W-1:0]  p1Damage, p2Damage, p1DamageNext, p2DamageNext;
  logic [DMG_W:0]    p1DamageSum, p2DamageSum;
  logic [31:0]       p1KbScaled, p2KbScaled, p1KbOut, p2KbOut;
  logic              p1KbValid, p2KbValid, clashReg;
  logic              p1Cand, p2Cand, p1Victim, p2Victim, clashNow;
  logic              unusedBits;

  assign unusedBits = ^{p1_attack[31:12], p2_attack[31:12]};

  assign p1Stun = (p1StunCount != '0);
  assign p2Stun = (p2StunCount != '0);

  // Decode attack type and qualify a new hit for each player
  always_comb begin
    p1Type  = decodeType(p1_attack[SPEC_N:SMASH_U]);
    p2Type  = decodeType(p2_attack[SPEC_N:SMASH_U]);
    p1HitEv = p1_attack[HIT] & p1_attack[ACTIVE] & ~p1Consumed & ~p1Lockout
              & ~p1Stun & p1Type.valid;
    p2HitEv = p2_attack[HIT] & p2_attack[ACTIVE] & ~p2Consumed & ~p2Lockout
              & ~p2Stun & p2Type.valid;
  end

  // Victim damage after the opponent's latched hit, saturating
  always_comb begin
    p1DamageSum  = {1'b0, p1Damage} + (DMG_W+1)'(p2Hit.dmg);
    p2DamageSum  = {1'b0, p2Damage} + (DMG_W+1)'(p1Hit.dmg);
    p1DamageNext = (p1DamageSum > DMG_LIMIT) ? DMG_CAP : p1DamageSum[DMG_W-1:0];
    p2DamageNext = (p2DamageSum > DMG_LIMIT) ? DMG_CAP : p2DamageSum[DMG_W-1:0];
  end

  // Player 1 is scaled by player 2's base knockback and vice versa
  kb_scaler #(.DMG_W(DMG_W)) uP1KbX (.base(p2KbBase[31:16]), .damage(p1DamageNext), .scaled(p1KbScaled[31:16]));
  kb_scaler #(.DMG_W(DMG_W)) uP1KbY (.base(p2KbBase[15:0]),  .damage(p1DamageNext), .scaled(p1KbScaled[15:0]));
  kb_scaler #(.DMG_W(DMG_W)) uP2KbX (.base(p1KbBase[31:16]), .damage(p2DamageNext), .scaled(p2KbScaled[31:16]));
  kb_scaler #(.DMG_W(DMG_W)) uP2KbY (.base(p1KbBase[15:0]),  .damage(p2DamageNext), .scaled(p2KbScaled[15:0]));

  // FSM state register
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Arbitration: choose a victim, a clash, or discard, one hit at a time
  always_comb begin
    stateNext = state;
    p1Victim  = 1'b0;
    p2Victim  = 1'b0;
    clashNow  = 1'b0;
    p1Cand    = p1Pending & ~p1Stun & ~p2Stun;
    p2Cand    = p2Pending & ~p2Stun & ~p1Stun;
    unique case (state)
      IDLE: begin
        if (p1Pending | p2Pending) stateNext = EVAL;
      end
      EVAL: begin
        stateNext = IDLE;
        if (p1Cand && p2Cand) begin
          if (p1Hit.tier > p2Hit.tier) begin
            p2Victim  = 1'b1;
            stateNext = APPLY;
          end else if (p2Hit.tier > p1Hit.tier) begin
            p1Victim  = 1'b1;
            stateNext = APPLY;
          end else begin
            clashNow = 1'b1;
          end
        end else if (p1Cand) begin
          p2Victim  = 1'b1;
          stateNext = APPLY;
        end else if (p2Cand) begin
          p1Victim  = 1'b1;
          stateNext = APPLY;
        end
      end
      APPLY: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Per-player hit capture: one hit per active period. The lockout flag is
  // loaded from ACTIVE during reset so a word held across reset must re-arm.
  always_ff @(posedge clock) begin
    if (!reset) begin
      p1Consumed <= 1'b0;
      p2Consumed <= 1'b0;
      p1Lockout  <= p1_attack[ACTIVE];
      p2Lockout  <= p2_attack[ACTIVE];
      p1Pending  <= 1'b0;
      p2Pending  <= 1'b0;
      p1Hit      <= '0;
      p2Hit      <= '0;
      p1KbBase   <= '0;
      p2KbBase   <= '0;
    end else begin
      if (!p1_attack[ACTIVE]) p1Lockout <= 1'b0;
      if (!p2_attack[ACTIVE]) p2Lockout <= 1'b0;
      if (p1HitEv) p1Consumed <= 1'b1;
      else if (!p1_attack[ACTIVE]) p1Consumed <= 1'b0;
      if (p2HitEv) p2Consumed <= 1'b1;
      else if (!p2_attack[ACTIVE]) p2Consumed <= 1'b0;
      if (p1HitEv) begin
        p1Pending <= 1'b1;
        p1Hit     <= p1Type;
        p1KbBase  <= p1_knockback;
      end else if (state == EVAL) begin
        p1Pending <= 1'b0;
      end
      if (p2HitEv) begin
        p2Pending <= 1'b1;
        p2Hit     <= p2Type;
        p2KbBase  <= p2_knockback;
      end else if (state == EVAL) begin
        p2Pending <= 1'b0;
      end
    end
  end

  // Victim updates are registered on the EVAL exit edge so that damage,
  // knockback and the strobe are all visible during the APPLY cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      p1Damage    <= '0;
      p2Damage    <= '0;
      p1KbOut     <= '0;
      p2KbOut     <= '0;
      p1KbValid   <= 1'b0;
      p2KbValid   <= 1'b0;
      p1StunCount <= '0;
      p2StunCount <= '0;
      clashReg    <= 1'b0;
    end else begin
      p1KbValid <= p1Victim;
      p2KbValid <= p2Victim;
      clashReg  <= clashNow;
      if (p1Victim) begin
        p1Damage    <= p1DamageNext;
        p1KbOut     <= p1KbScaled;
        p1StunCount <= STUN_CYCLES;
      end else if (p1Stun) begin
        p1StunCount <= p1StunCount - STUN_W'(1);
      end
      if (p2Victim) begin
        p2Damage    <= p2DamageNext;
        p2KbOut     <= p2KbScaled;
        p2StunCount <= STUN_CYCLES;
      end else if (p2Stun) begin
        p2StunCount <= p2StunCount - STUN_W'(1);
      end
    end
  end

  assign p1_damage   = p1Damage;
  assign p2_damage   = p2Damage;
  assign p1_kb_out   = p1KbOut;
  assign p2_kb_out   = p2KbOut;
  assign p1_kb_valid = p1KbValid;
  assign p2_kb_valid = p2KbValid;
  assign p1_stunned  = p1Stun;
  assign p2_stunned  = p2Stun;
  assign clash       = clashReg;

endmodule

// File: tb/tb_attack_arbiter.sv
// Self-checking bench for attack_arbiter with a shortened hitstun.
module tb_attack_arbiter;

  localparam int STUN = 20;

  logic        clock;
  logic        reset;
  logic [31:0] p1Attack, p1Kb, p2Attack, p2Kb;
  logic [9:0]  p1Damage, p2Damage;
  logic [31:0] p1KbOut, p2KbOut;
  logic        p1KbValid, p2KbValid, p1Stunned, p2Stunned, clashOut;

  int checks;
  int errors;
  int cnt;

  typedef struct {
    logic [31:0] a1, k1, a2, k2;
    logic [9:0]  d1, d2;
    logic [31:0] ko1, ko2;
    logic        v1, v2, s1, s2, cl;
  } vec_t;

  vec_t vecs[9];

  attack_arbiter #(
    .STUN_W(24),
    .STUN_CYCLES(24'd20),
    .DMG_W(10),
    .DMG_MAX(999)
  ) dut (
    .clock(clock),
    .reset(reset),
    .p1_attack(p1Attack),
    .p1_knockback(p1Kb),
    .p2_attack(p2Attack),
    .p2_knockback(p2Kb),
    .p1_damage(p1Damage),
    .p2_damage(p2Damage),
    .p1_kb_out(p1KbOut),
    .p1_kb_valid(p1KbValid),
    .p2_kb_out(p2KbOut),
    .p2_kb_valid(p2KbValid),
    .p1_stunned(p1Stunned),
    .p2_stunned(p2Stunned),
    .clash(clashOut)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic doReset();
    p1Attack = '0; p2Attack = '0; p1Kb = '0; p2Kb = '0;
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    //           a1          k1            a2          k2            d1     d2     ko1           ko2           v1 v2 s1 s2 cl
    vecs[0] = '{32'h0811, 32'h080000A0, 32'h0,     32'h0,        10'd0,  10'd15, 32'h0,        32'h08F000B2, 0, 1, 0, 1, 0};
    vecs[1] = '{32'h0821, 32'h0,        32'h0821,  32'h0,        10'd0,  10'd15, 32'h0,        32'h08F000B2, 0, 0, 0, 0, 1};
    vecs[2] = '{32'h0803, 32'h01000000, 32'h0821,  32'h0,        10'd0,  10'd30, 32'h0,        32'h013C0000, 0, 1, 0, 1, 0};
    vecs[3] = '{32'h0,    32'h0,        32'h0841,  32'hFF000040, 10'd10, 10'd30, 32'hFEEC0045, 32'h013C0000, 1, 0, 1, 0, 0};
    vecs[4] = '{32'h0C01, 32'h00400000, 32'h0821,  32'h0,        10'd10, 10'd38, 32'hFEEC0045, 32'h00530000, 0, 1, 0, 1, 0};
    vecs[5] = '{32'h0841, 32'h0,        32'h0C01,  32'h0,        10'd10, 10'd38, 32'hFEEC0045, 32'h00530000, 0, 0, 0, 0, 1};
    vecs[6] = '{32'h0841, 32'h0,        32'h0825,  32'h00000100, 10'd25, 10'd38, 32'h00000132, 32'h00530000, 1, 0, 1, 0, 0};
    vecs[7] = '{32'h0801, 32'h7FFF7FFF, 32'h0810,  32'h7FFF7FFF, 10'd25, 10'd38, 32'h00000132, 32'h00530000, 0, 0, 0, 0, 0};
    vecs[8] = '{32'h0,    32'h0,        32'h0821,  32'h80018000, 10'd28, 10'd38, 32'h80018001, 32'h00530000, 1, 0, 1, 0, 0};

    p1Attack = '0; p2Attack = '0; p1Kb = '0; p2Kb = '0;
    reset = 1'b0;
    repeat (3) tick();
    check("reset_damage", {22'd0, p1Damage}, 32'd0);
    check("reset_damage2", {22'd0, p2Damage}, 32'd0);
    check("reset_kbout", p1KbOut | p2KbOut, 32'd0);
    check("reset_flags", {27'd0, p1KbValid, p2KbValid, p1Stunned, p2Stunned, clashOut}, 32'd0);
    reset = 1'b1;
    tick();

    // One hit per attack instance
    p1Attack = 32'h0821; p1Kb = 32'h00100010;
    cnt = 0;
    repeat (100) begin tick(); if (p2KbValid) cnt++; end
    check("held_jab_pulses", cnt, 32'd1);
    check("held_jab_dmg", {22'd0, p2Damage}, 32'd3);
    p1Attack = '0; tick();
    p1Attack = 32'h0821;
    cnt = 0;
    repeat (10) begin tick(); if (p2KbValid) cnt++; end
    check("rearm_pulses", cnt, 32'd1);
    check("rearm_dmg", {22'd0, p2Damage}, 32'd6);

    // Table-driven single-shot vectors, cumulative state
    doReset();
    for (int i = 0; i < 9; i++) begin
      p1Attack = vecs[i].a1; p1Kb = vecs[i].k1;
      p2Attack = vecs[i].a2; p2Kb = vecs[i].k2;
      repeat (2) tick();
      check($sformatf("v%0d_early", i), {29'd0, p1KbValid, p2KbValid, clashOut}, 32'd0);
      tick();
      check($sformatf("v%0d_valid", i), {30'd0, p1KbValid, p2KbValid}, {30'd0, vecs[i].v1, vecs[i].v2});
      check($sformatf("v%0d_clash", i), {31'd0, clashOut}, {31'd0, vecs[i].cl});
      check($sformatf("v%0d_stun", i), {30'd0, p1Stunned, p2Stunned}, {30'd0, vecs[i].s1, vecs[i].s2});
      check($sformatf("v%0d_p1dmg", i), {22'd0, p1Damage}, {22'd0, vecs[i].d1});
      check($sformatf("v%0d_p2dmg", i), {22'd0, p2Damage}, {22'd0, vecs[i].d2});
      check($sformatf("v%0d_p1kb", i), p1KbOut, vecs[i].ko1);
      check($sformatf("v%0d_p2kb", i), p2KbOut, vecs[i].ko2);
      p1Attack = '0; p2Attack = '0;
      tick();
      check($sformatf("v%0d_strobe_end", i), {29'd0, p1KbValid, p2KbValid, clashOut}, 32'd0);
      repeat (STUN + 4) tick();
      check($sformatf("v%0d_stun_clear", i), {30'd0, p1Stunned, p2Stunned}, 32'd0);
    end

    // Damage saturation
    doReset();
    for (int n = 0; n < 66; n++) begin
      p1Attack = 32'h0811; p1Kb = '0;
      repeat (3) tick();
      p1Attack = '0;
      repeat (STUN + 2) tick();
    end
    check("sat_pre_dmg", {22'd0, p2Damage}, 32'd990);
    p1Attack = 32'h0811; p1Kb = 32'h70000000;
    repeat (3) tick();
    check("sat_valid", {31'd0, p2KbValid}, 32'd1);
    check("sat_dmg", {22'd0, p2Damage}, 32'd999);
    check("sat_kb", p2KbOut, 32'h7FFF0000);
    p1Attack = '0;
    repeat (STUN + 2) tick();
    p1Attack = 32'h0811; p1Kb = '0;
    repeat (3) tick();
    check("sat_nowrap_dmg", {22'd0, p2Damage}, 32'd999);
    p1Attack = '0;
    repeat (STUN + 2) tick();

    // Stun blocks the stunned player's hits; reset mid-stun clears all
    doReset();
    p2Attack = 32'h0821; p2Kb = 32'h00100010;
    repeat (3) tick();
    check("stun_hit_valid", {31'd0, p1KbValid}, 32'd1);
    check("stun_hit_dmg", {22'd0, p1Damage}, 32'd3);
    check("stun_hit_stunned", {31'd0, p1Stunned}, 32'd1);
    p2Attack = '0;
    p1Attack = 32'h0811; p1Kb = 32'h01000100;
    cnt = 0;
    repeat (5) begin tick(); if (p2KbValid) cnt++; end
    check("stunned_attack_pulses", cnt, 32'd0);
    check("stunned_attack_dmg", {22'd0, p2Damage}, 32'd0);
    check("still_stunned", {31'd0, p1Stunned}, 32'd1);
    reset = 1'b0;
    tick();
    check("midstun_reset_dmg", {12'd0, p1Damage, p2Damage}, 32'd0);
    check("midstun_reset_kb", p1KbOut | p2KbOut, 32'd0);
    check("midstun_reset_flags", {27'd0, p1KbValid, p2KbValid, p1Stunned, p2Stunned, clashOut}, 32'd0);
    reset = 1'b1;
    cnt = 0;
    repeat (10) begin tick(); if (p2KbValid) cnt++; end
    check("held_across_reset", cnt, 32'd0);
    p1Attack = '0; tick();
    p1Attack = 32'h0811;
    repeat (3) tick();
    check("post_reset_hit_valid", {31'd0, p2KbValid}, 32'd1);
    check("post_reset_hit_dmg", {22'd0, p2Damage}, 32'd15);
    check("post_reset_hit_kb", p2KbOut, 32'h011E011E);
    p1Attack = '0;
    repeat (STUN + 2) tick();

    // Reset landing on the APPLY edge suppresses the strobe
    p1Attack = 32'h0811; p1Kb = 32'h080000A0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check("midapply_valid", {31'd0, p2KbValid}, 32'd0);
    check("midapply_dmg", {22'd0, p2Damage}, 32'd0);
    check("midapply_stun", {31'd0, p2Stunned}, 32'd0);
    reset = 1'b1;
    p1Attack = '0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
